// File: rtl/pwm_seq_pkg.sv
// Shared definitions for the PWM frame sequencer: FSM state encoding,
// default sample width and the signed-to-offset-binary duty conversion.
package pwm_seq_pkg;

    localparam int WIDTH_DEFAULT = 12;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } state_t;

    // Flipping the sign bit maps two's complement onto 0..2^width-1, so the
    // caller truncates the result back to its own width.
    function automatic logic [31:0] to_offset_binary(input logic [31:0] sample,
                                                     input int unsigned width);
        return sample ^ (32'd1 << (width - 1));
    endfunction

endpackage

// File: rtl/pwm_compare.sv
// Free-running PWM frame counter and duty comparator. The pwm and frame_start
// outputs are registered together, so frame_start marks the pwm bit for cnt=0.
module pwm_compare
    import pwm_seq_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [WIDTH-1:0] duty,
    output logic             pwm,
    output logic [WIDTH-1:0] cnt,
    output logic             frame_start
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            pwm         <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            // Outside RUN the counter parks at zero so a new frame starts cleanly.
            cnt         <= run ? cnt + 1'b1 : '0;
            pwm         <= run & (cnt < duty);
            frame_start <= run & (cnt == '0);
        end
    end

endmodule

// File: rtl/pwm_frame_sequencer.sv
// Double-buffered sample sequencer feeding the PMOD PWM pin; samples swap only
// at frame boundaries. Define UNDERRUN_MUTE_EN to output midscale on underrun.
module pwm_frame_sequencer
    import pwm_seq_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_sample,
    output logic             pwm,
    output logic             frame_start,
    output logic             underrun
);

    localparam logic [WIDTH-1:0] CNT_LAST = '1;

    state_t                  state;
    logic signed [WIDTH-1:0] hold;
    logic signed [WIDTH-1:0] active;
    logic                    hold_full;
    logic [WIDTH-1:0]        cnt;
    logic [WIDTH-1:0]        duty;
    logic                    run;
    logic                    boundary;
    logic                    xfer;

    assign run      = (state == RUN);
    assign s_ready  = (state == PRIME) | (run & ~hold_full);
    assign xfer     = s_valid & s_ready;
    assign boundary = run & (cnt == CNT_LAST);
    assign duty     = WIDTH'(to_offset_binary(32'(active), WIDTH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            hold      <= '0;
            hold_full <= 1'b0;
            active    <= '0;
            underrun  <= 1'b0;
        end else if (!enable) begin
            state     <= IDLE;
            hold_full <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state <= PRIME;
                end
                PRIME: begin
                    // First sample bypasses the holding buffer.
                    if (xfer) begin
                        active <= s_sample;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    if (boundary && hold_full) begin
                        active    <= hold;
                        hold_full <= 1'b0;
                    end else begin
                        // A handshake landing on an empty-buffer boundary is kept
                        // for the following frame; the boundary still flags it.
                        if (boundary) begin
                            underrun <= 1'b1;
`ifdef UNDERRUN_MUTE_EN
                            active   <= '0;
`endif
                        end
                        if (xfer) begin
                            hold      <= s_sample;
                            hold_full <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    pwm_compare #(
        .WIDTH(WIDTH)
    ) u_compare (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .duty       (duty),
        .pwm        (pwm),
        .cnt        (cnt),
        .frame_start(frame_start)
    );

endmodule

// File: tb/tb_pwm_frame_sequencer.sv
// Self-checking bench for pwm_frame_sequencer at WIDTH=4 (16-clock frames),
// compared against a frame-level behavioural model of the sequencer.
module tb_pwm_frame_sequencer;

    localparam int W = 4;

    logic         clk      = 1'b0;
    logic         rst_n    = 1'b1;
    logic         enable   = 1'b0;
    logic         s_valid  = 1'b0;
    logic [W-1:0] s_sample = '0;
    logic         s_ready;
    logic         pwm;
    logic         frame_start;
    logic         underrun;
    wire  [3:0]   outs = {pwm, frame_start, s_ready, underrun};

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    pwm_frame_sequencer #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_sample   (s_sample),
        .pwm        (pwm),
        .frame_start(frame_start),
        .underrun   (underrun)
    );

    // Reference model: mode 0=idle, 1=waiting for first sample, 2=playing.
    // m_pos is the position within the frame, m_cur the signed sample playing,
    // m_q the at-most-one sample waiting for the next frame.
    int m_mode, m_pos, m_cur;
    int m_q[$];
    bit m_under, m_pwm, m_fs;

    function automatic int sgn(input logic [W-1:0] v);
        return (v >= 8) ? int'(v) - 16 : int'(v);
    endfunction

    function automatic bit model_ready();
        return (m_mode == 1) || (m_mode == 2 && m_q.size() == 0);
    endfunction

    function automatic logic [3:0] exp_vec();
        return {m_pwm, m_fs, model_ready(), m_under};
    endfunction

    task automatic model_reset();
        m_mode = 0; m_pos = 0; m_cur = 0; m_q.delete();
        m_under = 0; m_pwm = 0; m_fs = 0;
    endtask

    task automatic model_edge();
        bit hs;
        hs    = s_valid && model_ready();
        m_pwm = (m_mode == 2) && (m_pos < m_cur + 8);
        m_fs  = (m_mode == 2) && (m_pos == 0);
        if (!enable) begin
            m_mode = 0; m_q.delete(); m_under = 0; m_pos = 0;
        end else if (m_mode == 0) begin
            m_mode = 1;
        end else if (m_mode == 1) begin
            if (hs) begin m_cur = sgn(s_sample); m_mode = 2; m_pos = 0; end
        end else begin
            if (m_pos == 15) begin
                if (m_q.size() > 0) m_cur = m_q.pop_front();
                else begin
                    m_under = 1;
`ifdef UNDERRUN_MUTE_EN
                    m_cur = 0;
`endif
                end
            end
            if (hs) m_q.push_back(sgn(s_sample));
            m_pos = (m_pos + 1) % 16;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    // Observes one whole frame starting at a frame_start pulse (no checking here).
    task automatic measure_frame(output int highs, output bit found, output bit period_ok);
        highs = 0; found = 0; period_ok = 0;
        for (int k = 0; k < 40 && !frame_start; k++) step();
        if (frame_start) begin
            found = 1;
            highs = int'(pwm);
            for (int k = 0; k < 15; k++) begin step(); highs += int'(pwm); end
            step();
            period_ok = frame_start;
        end
    endtask

    task automatic test_reset();
        model_reset();
        #2 rst_n = 1'b0;
        #10;
        if (outs !== 4'b0000) begin fails++; $display("FAIL reset_outputs: got %b want 0000", outs); end
        checks++;
        rst_n = 1'b1; enable = 1'b1;
        step();
        if (outs !== exp_vec()) begin fails++; $display("FAIL reset_to_prime: got %b want %b", outs, exp_vec()); end
        checks++;
        if (s_ready !== 1'b1 || pwm !== 1'b0) begin fails++; $display("FAIL prime_ready: s_ready=%b pwm=%b want 1 0", s_ready, pwm); end
        checks++;
    endtask

    task automatic test_midscale();
        int h; bit f, p;
        s_valid = 1'b1; s_sample = 4'h0;
        for (int i = 0; i < 24; i++) begin
            step();
            if (outs !== exp_vec()) begin fails++; $display("FAIL midscale cycle %0d: got %b want %b", i, outs, exp_vec()); end
            checks++;
        end
        measure_frame(h, f, p);
        if (!f || h != 8) begin fails++; $display("FAIL midscale_duty: found=%0d highs=%0d want 8", f, h); end
        checks++;
        if (!p) begin fails++; $display("FAIL midscale_period: frame_start=%b 16 clocks later, want 1", frame_start); end
        checks++;
    endtask

    task automatic test_extremes();
        logic [W-1:0] smp [3] = '{4'h8, 4'h7, 4'hF};
        int           want[3] = '{0, 15, 7};
        int h; bit f, p;
        for (int t = 0; t < 3; t++) begin
            s_valid = 1'b1; s_sample = smp[t];
            for (int i = 0; i < 40; i++) begin
                step();
                if (outs !== exp_vec()) begin fails++; $display("FAIL extreme %h cycle %0d: got %b want %b", smp[t], i, outs, exp_vec()); end
                checks++;
            end
            measure_frame(h, f, p);
            if (!f || h != want[t]) begin fails++; $display("FAIL extreme_duty %h: highs=%0d want %0d", smp[t], h, want[t]); end
            checks++;
        end
    endtask

    task automatic test_backpressure();
        int xfers = 0;
        s_valid = 1'b1;
        for (int i = 0; i < 64; i++) begin
            s_sample = W'($urandom);
            if (s_ready === 1'b1) xfers++;
            step();
            if (outs !== exp_vec()) begin fails++; $display("FAIL backpressure cycle %0d: got %b want %b", i, outs, exp_vec()); end
            checks++;
        end
        if (xfers != 4) begin fails++; $display("FAIL backpressure_rate: %0d transfers in 4 frames, want 4", xfers); end
        checks++;
    endtask

    task automatic test_underrun();
        int h, want; bit f, p;
        s_valid = 1'b1; s_sample = 4'h3;
        for (int i = 0; i < 40; i++) begin
            step();
            if (outs !== exp_vec()) begin fails++; $display("FAIL underrun_fill cycle %0d: got %b want %b", i, outs, exp_vec()); end
            checks++;
        end
        s_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (outs !== exp_vec()) begin fails++; $display("FAIL underrun_drain cycle %0d: got %b want %b", i, outs, exp_vec()); end
            checks++;
        end
        if (underrun !== 1'b1) begin fails++; $display("FAIL underrun_flag: got %b want 1", underrun); end
        checks++;
`ifdef UNDERRUN_MUTE_EN
        want = 8;
`else
        want = 11;
`endif
        measure_frame(h, f, p);
        if (!f || h != want) begin fails++; $display("FAIL underrun_duty: highs=%0d want %0d", h, want); end
        checks++;
        enable = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            if (outs !== exp_vec()) begin fails++; $display("FAIL disable cycle %0d: got %b want %b", i, outs, exp_vec()); end
            checks++;
        end
        if (underrun !== 1'b0) begin fails++; $display("FAIL underrun_clear: got %b want 0", underrun); end
        checks++;
    endtask

    task automatic test_coincident();
        int h, want1; bit f, p;
        enable = 1'b1; s_valid = 1'b1; s_sample = 4'h5;
        for (int i = 0; i < 10 && m_mode != 2; i++) begin
            step();
            if (outs !== exp_vec()) begin fails++; $display("FAIL coinc_prime cycle %0d: got %b want %b", i, outs, exp_vec()); end
            checks++;
        end
        s_valid = 1'b0;
        for (int i = 0; i < 40 && m_pos != 15; i++) begin
            step();
            if (outs !== exp_vec()) begin fails++; $display("FAIL coinc_wait cycle %0d: got %b want %b", i, outs, exp_vec()); end
            checks++;
        end
        if (m_pos != 15) begin fails++; $display("FAIL coinc_timeout: frame end not reached, pos=%0d want 15", m_pos); end
        checks++;
        s_valid = 1'b1; s_sample = 4'hA;
        step();
        s_valid = 1'b0;
        if (underrun !== 1'b1 || s_ready !== 1'b0) begin fails++; $display("FAIL coinc_flag: underrun=%b s_ready=%b want 1 0", underrun, s_ready); end
        checks++;
`ifdef UNDERRUN_MUTE_EN
        want1 = 8;
`else
        want1 = 13;
`endif
        measure_frame(h, f, p);
        if (!f || h != want1) begin fails++; $display("FAIL coinc_next_frame: highs=%0d want %0d", h, want1); end
        checks++;
        measure_frame(h, f, p);
        if (!f || h != 2) begin fails++; $display("FAIL coinc_after_next: highs=%0d want 2", h); end
        checks++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            enable   = ($urandom_range(0, 60) != 0);
            s_valid  = ($urandom_range(0, 3) == 0);
            s_sample = W'($urandom);
            step();
            if (outs !== exp_vec()) begin fails++; $display("FAIL random cycle %0d: got %b want %b", i, outs, exp_vec()); end
            checks++;
        end
        enable = 1'b1;
    endtask

    task automatic test_reset_mid_run();
        s_valid = 1'b1; s_sample = 4'h2;
        for (int i = 0; i < 30; i++) begin
            step();
            if (outs !== exp_vec()) begin fails++; $display("FAIL prereset cycle %0d: got %b want %b", i, outs, exp_vec()); end
            checks++;
        end
        #2 rst_n = 1'b0;
        #1;
        if (outs !== 4'b0000) begin fails++; $display("FAIL async_reset: got %b want 0000", outs); end
        checks++;
        model_reset();
        #3 rst_n = 1'b1;
        step();
        if (s_ready !== 1'b1 || pwm !== 1'b0 || outs !== exp_vec()) begin
            fails++; $display("FAIL reset_reprime: got %b want %b", outs, exp_vec());
        end
        checks++;
    endtask

    initial begin
        test_reset();
        test_midscale();
        test_extremes();
        test_backpressure();
        test_underrun();
        test_coincident();
        test_random();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
